// File: rtl/legv8_pkg.sv
`default_nettype none
// legv8_pkg: LEGv8 instruction kinds, opcodes, field positions and format packers,
// shared between the instruction encoder and the control decoders.
package legv8_pkg;

  typedef enum logic [3:0] {
    KIND_LDUR  = 4'd0,
    KIND_STUR  = 4'd1,
    KIND_CBZ   = 4'd2,
    KIND_ADD   = 4'd3,
    KIND_SUB   = 4'd4,
    KIND_AND   = 4'd5,
    KIND_ORR   = 4'd6,
    KIND_ADDS  = 4'd7,
    KIND_SUBS  = 4'd8,
    KIND_ADDI  = 4'd9,
    KIND_SUBI  = 4'd10,
    KIND_ADDIS = 4'd11,
    KIND_SUBIS = 4'd12,
    KIND_BCOND = 4'd13
  } kind_t;

  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_ORR   = 11'b10101010000;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;

  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;

  localparam int RD_LSB      = 0;
  localparam int RN_LSB      = 5;
  localparam int R_SHAMT_LSB = 10;
  localparam int R_RM_LSB    = 16;
  localparam int R_OP_LSB    = 21;
  localparam int I_IMM_LSB   = 10;
  localparam int I_OP_LSB    = 22;
  localparam int D_OP2_LSB   = 10;
  localparam int D_ADDR_LSB  = 12;
  localparam int D_OP_LSB    = 21;
  localparam int CB_ADDR_LSB = 5;
  localparam int CB_OP_LSB   = 24;

  localparam int REG_W     = 5;
  localparam int SHAMT_W   = 6;
  localparam int I_IMM_W   = 12;
  localparam int D_ADDR_W  = 9;
  localparam int CB_ADDR_W = 19;

  function automatic logic [31:0] enc_r(logic [10:0] op, logic [4:0] rm,
                                        logic [4:0] rn, logic [4:0] rd);
    logic [31:0] w;
    w = '0;
    w[R_OP_LSB +: 11]         = op;
    w[R_RM_LSB +: REG_W]      = rm;
    w[R_SHAMT_LSB +: SHAMT_W] = '0;
    w[RN_LSB +: REG_W]        = rn;
    w[RD_LSB +: REG_W]        = rd;
    return w;
  endfunction

  function automatic logic [31:0] enc_i(logic [9:0] op, logic [11:0] imm,
                                        logic [4:0] rn, logic [4:0] rd);
    logic [31:0] w;
    w = '0;
    w[I_OP_LSB +: 10]        = op;
    w[I_IMM_LSB +: I_IMM_W]  = imm;
    w[RN_LSB +: REG_W]       = rn;
    w[RD_LSB +: REG_W]       = rd;
    return w;
  endfunction

  function automatic logic [31:0] enc_d(logic [10:0] op, logic [8:0] addr,
                                        logic [4:0] rn, logic [4:0] rt);
    logic [31:0] w;
    w = '0;
    w[D_OP_LSB +: 11]          = op;
    w[D_ADDR_LSB +: D_ADDR_W]  = addr;
    w[D_OP2_LSB +: 2]          = 2'b00;
    w[RN_LSB +: REG_W]         = rn;
    w[RD_LSB +: REG_W]         = rt;
    return w;
  endfunction

  function automatic logic [31:0] enc_cb(logic [7:0] op, logic [18:0] addr,
                                         logic [4:0] rt);
    logic [31:0] w;
    w = '0;
    w[CB_OP_LSB +: 8]           = op;
    w[CB_ADDR_LSB +: CB_ADDR_W] = addr;
    w[RD_LSB +: REG_W]          = rt;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/legv8_instr_pack.sv
`default_nettype none
// legv8_instr_pack: combinational kind + fields -> 32-bit LEGv8 machine word.
// Unknown kinds yield the all-zero word and raise invalid.
module legv8_instr_pack (
  input  logic [3:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  output logic [31:0] word,
  output logic        invalid
);
  import legv8_pkg::*;

  always_comb begin
    word    = 32'h0;
    invalid = 1'b0;
    case (kind)
      KIND_LDUR:  word = enc_d(OP_LDUR, imm[8:0], rn, rd);
      KIND_STUR:  word = enc_d(OP_STUR, imm[8:0], rn, rd);
      KIND_CBZ:   word = enc_cb(OP_CBZ, imm, rd);
      KIND_ADD:   word = enc_r(OP_ADD, rm, rn, rd);
      KIND_SUB:   word = enc_r(OP_SUB, rm, rn, rd);
      KIND_AND:   word = enc_r(OP_AND, rm, rn, rd);
      KIND_ORR:   word = enc_r(OP_ORR, rm, rn, rd);
      KIND_ADDS:  word = enc_r(OP_ADDS, rm, rn, rd);
      KIND_SUBS:  word = enc_r(OP_SUBS, rm, rn, rd);
      KIND_ADDI:  word = enc_i(OP_ADDI, imm[11:0], rn, rd);
      KIND_SUBI:  word = enc_i(OP_SUBI, imm[11:0], rn, rd);
      KIND_ADDIS: word = enc_i(OP_ADDIS, imm[11:0], rn, rd);
      KIND_SUBIS: word = enc_i(OP_SUBIS, imm[11:0], rn, rd);
      // B.cond carries the condition code in the Rt slot
      KIND_BCOND: word = enc_cb(OP_BCOND, imm, rd);
      default:    invalid = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/legv8_instr_encoder.sv
`default_nettype none
// legv8_instr_encoder: symbolic instruction loader writing packed LEGv8 words to imem.
// Define IMEM_PAD_EN to zero-fill the remaining memory after finish.
module legv8_instr_encoder #(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_kind,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rn,
  input  logic [4:0]    in_rm,
  input  logic [18:0]   in_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
  output logic          bad_kind
);
  import legv8_pkg::*;

  localparam int         AW_P1   = AW + 1;
  localparam logic [AW:0] DEPTH_C = AW_P1'(IMEM_DEPTH);
  localparam logic [AW:0] CNT_ONE = AW_P1'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef IMEM_PAD_EN
  localparam logic [1:0] S_PAD  = 2'd3;
  localparam logic [AW:0] LAST_C = DEPTH_C - CNT_ONE;
`endif

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] pack_word;
  logic        pack_invalid;
  logic        accept;
  logic        wr_en;
  logic [31:0] wr_word;
  logic        wr_bad;
  logic        session_start;

  legv8_instr_pack u_pack (
    .kind    (in_kind),
    .rd      (in_rd),
    .rn      (in_rn),
    .rm      (in_rm),
    .imm     (in_imm),
    .word    (pack_word),
    .invalid (pack_invalid)
  );

  assign full = (count == DEPTH_C);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (finish) begin
`ifdef IMEM_PAD_EN
          state_d = S_PAD;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef IMEM_PAD_EN
      // leave on the cycle that performs the last fill write
      S_PAD:  if (full || count == LAST_C) state_d = S_DONE;
`endif
      S_DONE: if (start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state_q == S_LOAD) && !full;
    done          = (state_q == S_DONE);
    accept        = in_valid && in_ready;
    wr_en         = accept;
    wr_word       = pack_word;
    wr_bad        = accept && pack_invalid;
    session_start = start && ((state_q == S_IDLE) || (state_q == S_DONE));
`ifdef IMEM_PAD_EN
    if ((state_q == S_PAD) && !full) begin
      wr_en   = 1'b1;
      wr_word = 32'h0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'h0;
      bad_kind   <= 1'b0;
    end else begin
      imem_we <= wr_en;
      if (wr_en) begin
        imem_addr  <= count[AW-1:0];
        imem_wdata <= wr_word;
      end
      if (session_start) begin
        count    <= '0;
        bad_kind <= 1'b0;
      end else begin
        if (wr_en)  count    <= count + CNT_ONE;
        if (wr_bad) bad_kind <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_legv8_instr_encoder.sv
`default_nettype none
// tb_legv8_instr_encoder: directed and randomized checks of the LEGv8 instruction loader
// against an arithmetic encoding model; honours IMEM_PAD_EN.
module tb_legv8_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset, start, finish, in_valid, in_ready;
  logic [3:0]    in_kind;
  logic [4:0]    in_rd, in_rn, in_rm;
  logic [18:0]   in_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full, done, bad_kind;

  int n_vec = 0;
  int n_err = 0;

  legv8_instr_encoder #(.IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .full(full), .done(done), .bad_kind(bad_kind)
  );

  always #5 clk = ~clk;

  // Machine word computed as opcode * 2^pos + field * 2^pos sums.
  function automatic logic [31:0] ref_encode(int kind, int rd, int rn, int rm, int imm);
    longint w;
    longint op;
    w = 0;
    case (kind)
      0, 1: begin
        op = (kind == 0) ? 1986 : 1984;
        w  = op * (64'd1 << 21) + (imm % 512) * 4096 + rn * 32 + rd;
      end
      2, 13: begin
        op = (kind == 2) ? 180 : 84;
        w  = op * (64'd1 << 24) + (imm % 524288) * 32 + rd;
      end
      3, 4, 5, 6, 7, 8: begin
        case (kind)
          3: op = 1112;
          4: op = 1624;
          5: op = 1104;
          6: op = 1360;
          7: op = 1368;
          default: op = 1880;
        endcase
        w = op * (64'd1 << 21) + rm * 65536 + rn * 32 + rd;
      end
      9, 10, 11, 12: begin
        case (kind)
          9: op = 580;
          10: op = 836;
          11: op = 708;
          default: op = 964;
        endcase
        w = op * (64'd1 << 22) + (imm % 4096) * 1024 + rn * 32 + rd;
      end
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int kind, input int rd, input int rn,
                       input int rm, input int imm);
    in_valid = v;
    in_kind  = 4'(kind);
    in_rd    = 5'(rd);
    in_rn    = 5'(rn);
    in_rm    = 5'(rm);
    in_imm   = 19'(imm);
  endtask

  // After finish: follow any zero-fill writes until done, bounded.
  task automatic drain_session(input int cnt_at_finish);
    int exp_addr;
    int exp_end;
    int guard;
    exp_addr = cnt_at_finish;
    guard    = 0;
`ifdef IMEM_PAD_EN
    exp_end = DEPTH;
`else
    exp_end = cnt_at_finish;
`endif
    while (!done && guard < DEPTH + 4) begin
      step();
      guard++;
      if (imem_we) begin
        n_vec++;
        if (exp_addr >= exp_end || int'(imem_addr) !== exp_addr || imem_wdata !== 32'h0) begin
          n_err++;
          $display("FAIL drain_write got addr=%0d data=%h want addr=%0d data=0 (limit %0d)",
                   imem_addr, imem_wdata, exp_addr, exp_end);
        end
        exp_addr++;
      end
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL drain_done got %b want 1 after %0d cycles", done, guard);
    end
    n_vec++;
    if (exp_addr != exp_end || int'(count) != exp_end) begin
      n_err++;
      $display("FAIL drain_count got writes_to=%0d count=%0d want %0d", exp_addr, count, exp_end);
    end
    n_vec++;
    if (full !== (exp_end == DEPTH)) begin
      n_err++;
      $display("FAIL drain_full got %b want %b", full, exp_end == DEPTH);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; finish = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    n_vec++;
    if ({in_ready, imem_we, full, done, bad_kind} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got rdy/we/full/done/bad=%b want 00000",
               {in_ready, imem_we, full, done, bad_kind});
    end
    n_vec++;
    if (imem_addr !== '0 || imem_wdata !== 32'h0 || count !== '0) begin
      n_err++;
      $display("FAIL reset_regs got addr=%0d data=%h count=%0d want 0", imem_addr, imem_wdata, count);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle got in_ready=%b done=%b want 0 0", in_ready, done);
    end
  endtask

  task automatic test_encode_sequence();
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || count !== '0) begin
      n_err++;
      $display("FAIL start_load got in_ready=%b count=%0d want 1 0", in_ready, count);
    end
    drive(1, 3, 1, 2, 3, 0);
    step();
    n_vec++;
    if ({imem_we, imem_addr, imem_wdata, count} !== {1'b1, 2'd0, 32'h8B030041, 3'd1}) begin
      n_err++;
      $display("FAIL add_word got we=%b addr=%0d data=%h count=%0d want 1 0 8b030041 1",
               imem_we, imem_addr, imem_wdata, count);
    end
    drive(1, 0, 9, 10, 0, 8);
    step();
    n_vec++;
    if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 2'd1, 32'hF8408149}) begin
      n_err++;
      $display("FAIL ldur_word got we=%b addr=%0d data=%h want 1 1 f8408149", imem_we, imem_addr, imem_wdata);
    end
    drive(1, 2, 5, 0, 0, 19'h7FFFE);
    step();
    n_vec++;
    if ({imem_we, imem_addr, imem_wdata, count} !== {1'b1, 2'd2, 32'hB4FFFFC5, 3'd3}) begin
      n_err++;
      $display("FAIL cbz_word got we=%b addr=%0d data=%h count=%0d want 1 2 b4ffffc5 3",
               imem_we, imem_addr, imem_wdata, count);
    end
    drive(1, 15, 7, 7, 7, 7);
    step();
    n_vec++;
    if ({imem_we, imem_addr, imem_wdata, bad_kind} !== {1'b1, 2'd3, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL bad_kind_write got we=%b addr=%0d data=%h bad=%b want 1 3 0 1",
               imem_we, imem_addr, imem_wdata, bad_kind);
    end
    n_vec++;
    if (count !== 3'd4 || full !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_state got count=%0d full=%b in_ready=%b want 4 1 0", count, full, in_ready);
    end
    drive(1, 3, 1, 1, 1, 0);
    step();
    n_vec++;
    if (imem_we !== 1'b0 || count !== 3'd4) begin
      n_err++;
      $display("FAIL full_ignores got we=%b count=%0d want 0 4", imem_we, count);
    end
    drive(0, 0, 0, 0, 0, 0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    drain_session(4);
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++;
    if ({bad_kind, done, in_ready, count} !== {1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL restart got bad=%b done=%b in_ready=%b count=%0d want 0 0 1 0",
               bad_kind, done, in_ready, count);
    end
  endtask

  // Enters already in LOAD with count 0.
  task automatic test_pad();
    for (int i = 0; i < 2; i++) begin
      int rd, rn, rm;
      rd = $urandom_range(0, 31); rn = $urandom_range(0, 31); rm = $urandom_range(0, 31);
      drive(1, 6, rd, rn, rm, 0);
      step();
      n_vec++;
      if (imem_we !== 1'b1 || int'(imem_addr) !== i || imem_wdata !== ref_encode(6, rd, rn, rm, 0)) begin
        n_err++;
        $display("FAIL pad_pre_write got we=%b addr=%0d data=%h want 1 %0d %h",
                 imem_we, imem_addr, imem_wdata, i, ref_encode(6, rd, rn, rm, 0));
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    finish = 1'b1;
    step();
    finish = 1'b0;
    drain_session(2);
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      int cnt;
      int n;
      bit bad;
      cnt = 0;
      bad = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      n_vec++;
      if (in_ready !== 1'b1 || count !== '0 || bad_kind !== 1'b0) begin
        n_err++;
        $display("FAIL rnd_start s=%0d got in_ready=%b count=%0d bad=%b want 1 0 0",
                 s, in_ready, count, bad_kind);
      end
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        int k, rd, rn, rm, imm;
        bit v, acc;
        logic [31:0] exp_w;
        v   = ($urandom_range(0, 9) < 7);
        k   = $urandom_range(0, 15);
        rd  = $urandom_range(0, 31);
        rn  = $urandom_range(0, 31);
        rm  = $urandom_range(0, 31);
        imm = $urandom_range(0, 524287);
        drive(v, k, rd, rn, rm, imm);
        finish = (i == n - 1);
        n_vec++;
        if (in_ready !== (cnt < DEPTH)) begin
          n_err++;
          $display("FAIL rnd_ready s=%0d got %b want %b", s, in_ready, cnt < DEPTH);
        end
        acc   = v && (cnt < DEPTH);
        exp_w = ref_encode(k, rd, rn, rm, imm);
        step();
        n_vec++;
        if (imem_we !== acc || (acc && (int'(imem_addr) !== cnt || imem_wdata !== exp_w))) begin
          n_err++;
          $display("FAIL rnd_write s=%0d kind=%0d got we=%b addr=%0d data=%h want we=%b addr=%0d data=%h",
                   s, k, imem_we, imem_addr, imem_wdata, acc, cnt, exp_w);
        end
        if (acc) begin
          cnt++;
          if (k > 13) bad = 1;
        end
        n_vec++;
        if (int'(count) !== cnt || bad_kind !== bad) begin
          n_err++;
          $display("FAIL rnd_count s=%0d got count=%0d bad=%b want %0d %b", s, count, bad_kind, cnt, bad);
        end
      end
      finish = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      drain_session(cnt);
    end
  endtask

  task automatic test_reset_abort();
    start = 1'b1;
    step();
    start = 1'b0;
    drive(1, 4, 3, 4, 5, 0);
    step();
    n_vec++;
    if (imem_we !== 1'b1) begin
      n_err++;
      $display("FAIL abort_pre_write got we=%b want 1", imem_we);
    end
    drive(1, 4, 6, 7, 8, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({imem_we, in_ready, done, bad_kind, count} !== {4'b0, 3'd0}) begin
      n_err++;
      $display("FAIL abort_reset got we=%b in_ready=%b done=%b bad=%b count=%0d want all 0",
               imem_we, in_ready, done, bad_kind, count);
    end
    step();
    n_vec++;
    if (imem_we !== 1'b0 || in_ready !== 1'b0 || count !== '0) begin
      n_err++;
      $display("FAIL abort_idle got we=%b in_ready=%b count=%0d want 0 0 0", imem_we, in_ready, count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || count !== '0) begin
      n_err++;
      $display("FAIL abort_restart got in_ready=%b count=%0d want 1 0", in_ready, count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_encode_sequence();
    test_pad();
    test_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
